// File: rtl/pixel_readback_if.sv
// Plot/read bus shared by the processor, the VGA adapter and the pixel readback mirror.
// master = processor/game-logic side, slave = readback responder.
interface pixel_readback_if;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [2:0] wr_color;
  logic       plot;
  logic       clear_req;
  logic       clear_busy;
  logic       rd_req;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_ready;
  logic       rd_valid;
  logic [2:0] rd_color;
  logic       rd_oob;

  modport master (
    output wr_x, wr_y, wr_color, plot, clear_req, rd_req, rd_x, rd_y,
    input  clear_busy, rd_ready, rd_valid, rd_color, rd_oob
  );

  modport slave (
    input  wr_x, wr_y, wr_color, plot, clear_req, rd_req, rd_x, rd_y,
    output clear_busy, rd_ready, rd_valid, rd_color, rd_oob
  );
endinterface

// File: rtl/pixel_readback.sv
// Shadow framebuffer mirroring the VGA plot stream; answers pipelined pixel reads
// (3-cycle latency) and runs a whole-frame clear sweep after reset or on request.
module pixel_readback #(
  parameter int         XRES        = 160,
  parameter int         YRES        = 120,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  pixel_readback_if.slave bus
);
  localparam int         DEPTH   = XRES * YRES;
  localparam logic [7:0] XMAX    = 8'(XRES);
  localparam logic [6:0] YMAX    = 7'(YRES);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    if (XRES == 160)
      return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    else
      return 15'(int'(y) * XRES + int'(x));
  endfunction

  logic [0:0]  r_state;
  logic [14:0] r_clr_cnt;
  logic [2:0]  r_mem [0:DEPTH-1];
  logic [2:0]  r_mem_q;
  logic        r_s1_valid, r_s1_oob, r_s2_valid, r_s2_oob;
  logic [14:0] r_s1_addr;
  logic        r_rd_valid, r_rd_oob;
  logic [2:0]  r_rd_color;

  logic        w_clearing, w_wr_in, w_rd_in, w_rd_acc, w_we, w_rd_en;
  logic [14:0] w_waddr;
  logic [2:0]  w_wdata;

  assign w_clearing = (r_state == S_CLEAR);
  assign w_wr_in    = (bus.wr_x < XMAX) && (bus.wr_y < YMAX);
  assign w_rd_in    = (bus.rd_x < XMAX) && (bus.rd_y < YMAX);
  assign w_rd_acc   = bus.rd_req && !w_clearing;

  // The sweep owns the single write port while clearing; plots are dropped then.
  assign w_we    = w_clearing || (bus.plot && w_wr_in);
  assign w_waddr = w_clearing ? r_clr_cnt : pix_addr(bus.wr_x, bus.wr_y);
  assign w_wdata = w_clearing ? CLEAR_COLOR : bus.wr_color;
  assign w_rd_en = r_s1_valid && !r_s1_oob;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == 15'(DEPTH - 1)) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 15'd1;
          end
        end
        S_IDLE: begin
          if (bus.clear_req) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Block RAM: write-then-read at different edges gives old data on same-edge collisions.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= w_wdata;
    if (w_rd_en)
      r_mem_q <= r_mem[r_s1_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_oob   <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_oob   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_color <= '0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_oob  <= !w_rd_in;
        r_s1_addr <= w_rd_in ? pix_addr(bus.rd_x, bus.rd_y) : '0;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_oob   <= r_s1_oob;
      r_rd_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_rd_color <= r_s2_oob ? CLEAR_COLOR : r_mem_q;
        r_rd_oob   <= r_s2_oob;
      end
    end
  end

  assign bus.clear_busy = w_clearing;
  assign bus.rd_ready   = !w_clearing;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_color   = r_rd_color;
  assign bus.rd_oob     = r_rd_oob;
endmodule

// File: tb/tb_pixel_readback.sv
// Directed, table-driven check of the pixel readback mirror: reset/clear timing,
// read latency and coherence, range handling, clear overwrite and reset kill.
module tb_pixel_readback;
  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  pixel_readback_if bus();

  pixel_readback #(.XRES(160), .YRES(120), .CLEAR_COLOR(3'b000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       plot;
    logic [7:0] wx;
    logic [6:0] wy;
    logic [2:0] wc;
    logic       rd;
    logic [7:0] rx;
    logic [6:0] ry;
    logic       ev;
    logic [2:0] ec;
    logic       eo;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic p, input int wx, input int wy, input int wc,
                              input logic r, input int rx, input int ry,
                              input logic ev, input int ec, input logic eo);
    vec_t v;
    v.plot = p;  v.wx = 8'(wx); v.wy = 7'(wy); v.wc = 3'(wc);
    v.rd   = r;  v.rx = 8'(rx); v.ry = 7'(ry);
    v.ev   = ev; v.ec = 3'(ec); v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.plot = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_color = '0;
    bus.clear_req = 1'b0; bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
  endtask

  // Ticks until rd_valid is seen; returns edges elapsed, or -1 on timeout.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.rd_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Counts cycles until clear_busy falls, plus stray rd_ready / rd_valid cycles.
  task automatic count_busy(input int start, output int n, output int bad_ready, output int bad_valid);
    n = start; bad_ready = 0; bad_valid = 0;
    while (bus.clear_busy && n < 30000) begin
      if (bus.rd_ready) bad_ready++;
      if (bus.rd_valid) bad_valid++;
      tick();
      n++;
    end
  endtask

  initial begin
    int n, bad_ready, bad_valid, cyc;

    vecs[0]  = mk(0,   0,   0, 0, 1, 159, 119, 0, 0, 0);
    vecs[1]  = mk(1, 159, 119, 5, 1, 159, 119, 0, 0, 0);
    vecs[2]  = mk(1,   0,   0, 1, 0,   0,   0, 1, 0, 0);
    vecs[3]  = mk(1,   1,   0, 2, 0,   0,   0, 1, 5, 0);
    vecs[4]  = mk(1,   2,   0, 4, 0,   0,   0, 0, 5, 0);
    vecs[5]  = mk(0,   0,   0, 0, 1,   0,   0, 0, 5, 0);
    vecs[6]  = mk(0,   0,   0, 0, 1,   1,   0, 0, 5, 0);
    vecs[7]  = mk(0,   0,   0, 0, 1,   2,   0, 1, 1, 0);
    vecs[8]  = mk(1, 160,   5, 7, 0,   0,   0, 1, 2, 0);
    vecs[9]  = mk(0,   0,   0, 0, 1, 160,   5, 1, 4, 0);
    vecs[10] = mk(0,   0,   0, 0, 1,   0,   6, 0, 4, 0);
    vecs[11] = mk(0,   0,   0, 0, 0,   0,   0, 1, 0, 1);
    vecs[12] = mk(0,   0,   0, 0, 0,   0,   0, 1, 0, 0);
    vecs[13] = mk(0,   0,   0, 0, 1,   5, 120, 0, 0, 0);
    vecs[14] = mk(0,   0,   0, 0, 0,   0,   0, 0, 0, 0);
    vecs[15] = mk(0,   0,   0, 0, 0,   0,   0, 1, 0, 1);
    vecs[16] = mk(0,   0,   0, 0, 0,   0,   0, 0, 0, 1);

    // Power-up: reset with a read of (0,0) held pending.
    reset = 1'b1;
    idle_inputs();
    bus.rd_req = 1'b1;
    repeat (3) tick();
    check("reset clear_busy", int'(bus.clear_busy), 1);
    check("reset rd_ready",   int'(bus.rd_ready),   0);
    check("reset rd_valid",   int'(bus.rd_valid),   0);
    check("reset rd_color",   int'(bus.rd_color),   0);
    check("reset rd_oob",     int'(bus.rd_oob),     0);

    // Interrupt the power-up sweep at counter 5000; it must restart from scratch.
    reset = 1'b0;
    repeat (5000) tick();
    check("busy at cnt 5000", int'(bus.clear_busy), 1);
    reset = 1'b1;
    #1;
    check("busy in mid-clear reset", int'(bus.clear_busy), 1);
    repeat (2) tick();
    reset = 1'b0;
    count_busy(0, n, bad_ready, bad_valid);
    check("power-up clear length", n, 19200);
    check("rd_ready low while clearing", bad_ready, 0);
    check("no rd_valid while clearing", bad_valid, 0);
    check("rd_ready after clear", int'(bus.rd_ready), 1);

    tick();
    bus.rd_req = 1'b0;
    wait_valid(cyc);
    check("first read latency", cyc, 2);
    check("first read colour", int'(bus.rd_color), 0);
    check("first read oob", int'(bus.rd_oob), 0);
    tick();

    // Table: one row per edge, expected outputs sampled just after that edge.
    for (int i = 0; i < 17; i++) begin
      bus.plot = vecs[i].plot; bus.wr_x = vecs[i].wx; bus.wr_y = vecs[i].wy;
      bus.wr_color = vecs[i].wc;
      bus.rd_req = vecs[i].rd; bus.rd_x = vecs[i].rx; bus.rd_y = vecs[i].ry;
      tick();
      check($sformatf("row%0d rd_valid", i), int'(bus.rd_valid), int'(vecs[i].ev));
      check($sformatf("row%0d rd_color", i), int'(bus.rd_color), int'(vecs[i].ec));
      check($sformatf("row%0d rd_oob",   i), int'(bus.rd_oob),   int'(vecs[i].eo));
    end
    idle_inputs();

    // Clear request: a read accepted on the entry edge still sees pre-clear data,
    // and a plot issued during the sweep is discarded.
    bus.plot = 1'b1; bus.wr_x = 8'd10; bus.wr_y = 7'd10; bus.wr_color = 3'b110;
    tick();
    idle_inputs();
    bus.clear_req = 1'b1;
    bus.rd_req = 1'b1; bus.rd_x = 8'd10; bus.rd_y = 7'd10;
    tick();
    idle_inputs();
    check("busy on clear entry", int'(bus.clear_busy), 1);
    check("rd_ready on clear entry", int'(bus.rd_ready), 0);
    bus.plot = 1'b1; bus.wr_x = 8'd10; bus.wr_y = 7'd10; bus.wr_color = 3'b011;
    tick();
    idle_inputs();
    tick();
    check("pre-clear read valid", int'(bus.rd_valid), 1);
    check("pre-clear read colour", int'(bus.rd_color), 6);
    count_busy(2, n, bad_ready, bad_valid);
    check("requested clear length", n, 19200);
    check("rd_ready low during requested clear", bad_ready, 0);
    bus.rd_req = 1'b1; bus.rd_x = 8'd10; bus.rd_y = 7'd10;
    tick();
    idle_inputs();
    wait_valid(cyc);
    check("post-clear read latency", cyc, 2);
    check("post-clear (10,10) colour", int'(bus.rd_color), 0);
    bus.rd_req = 1'b1; bus.rd_x = 8'd159; bus.rd_y = 7'd119;
    tick();
    idle_inputs();
    wait_valid(cyc);
    check("post-clear (159,119) latency", cyc, 2);
    check("post-clear (159,119) colour", int'(bus.rd_color), 0);

    // Reset one cycle after a read is accepted: its response must never appear.
    bus.rd_req = 1'b1; bus.rd_x = 8'd3; bus.rd_y = 7'd3;
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    #1;
    check("killed read rd_valid", int'(bus.rd_valid), 0);
    check("busy after read-kill reset", int'(bus.clear_busy), 1);
    repeat (2) tick();
    check("rd_valid held in reset", int'(bus.rd_valid), 0);
    reset = 1'b0;
    count_busy(0, n, bad_ready, bad_valid);
    check("clear length after read-kill reset", n, 19200);
    check("no stray rd_valid after reset", bad_valid, 0);
    repeat (4) begin
      tick();
      if (bus.rd_valid) bad_valid++;
    end
    check("no late rd_valid after clear", bad_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
